// File: rtl/icetap_capture_ctrl.sv
// ----------------------------------------------------------------------------
// icetap_capture_ctrl : IceTap sample capture, masked trigger and circular buffer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module icetap_capture_ctrl #(
  parameter int NR_SIGNALS = 1,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NR_SIGNALS-1:0] signals_in,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NR_SIGNALS-1:0] trig_mask,
  input  logic [NR_SIGNALS-1:0] trig_value,
  input  logic [DEPTH_LOG2-1:0] post_count,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [NR_SIGNALS-1:0] rd_data,
  output logic                  armed,
  output logic                  triggered,
  output logic                  done,
  output logic                  wrapped,
  output logic [DEPTH_LOG2-1:0] trig_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NR_SIGNALS-1:0] sample;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DEPTH_LOG2-1:0] post_cnt;
  logic                  hit;
  logic                  wr_en;
  logic                  restart;
  logic                  trig_capture;

  logic [NR_SIGNALS-1:0] mem [0:DEPTH-1];

  assign hit = ((sample ^ trig_value) & trig_mask) == '0;

  // Control precedence: abort, then start, then the per-state behaviour.
  always_comb begin
    state_d      = state_q;
    wr_en        = 1'b0;
    restart      = 1'b0;
    trig_capture = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_ARMED;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_ARMED: begin
          wr_en = 1'b1;
          if (hit) begin
            trig_capture = 1'b1;
            state_d      = (post_cnt == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          wr_en = 1'b1;
          if (post_cnt == DEPTH_LOG2'(1)) begin
            state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      armed     <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed     <= (state_d == S_ARMED);
      triggered <= (state_d == S_POST) || (state_d == S_DONE);
      done      <= (state_d == S_DONE);
    end
  end

  // The post_count port is DEPTH_LOG2 bits wide, so it already tops out at
  // DEPTH-1 and the trigger sample can never be overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample    <= '0;
      wr_addr   <= '0;
      post_cnt  <= '0;
      wrapped   <= 1'b0;
      trig_addr <= '0;
    end else begin
      sample <= signals_in;
      if (restart) begin
        wr_addr  <= '0;
        wrapped  <= 1'b0;
        post_cnt <= post_count;
      end else if (wr_en) begin
        wr_addr <= wr_addr + DEPTH_LOG2'(1);
        if (&wr_addr) begin
          wrapped <= 1'b1;
        end
        if (state_q == S_POST) begin
          post_cnt <= post_cnt - DEPTH_LOG2'(1);
        end
      end
      if (trig_capture) begin
        trig_addr <= wr_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= sample;
    end
  end

  // Read-before-write: a same-address read returns the previous contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icetap_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_icetap_capture_ctrl : directed capture scenarios with a read-port scoreboard
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_icetap_capture_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] signals_in = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] trig_mask = 8'hFF;
  logic [7:0] trig_value = '0;
  logic [3:0] post_count = '0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       armed;
  logic       triggered;
  logic       done;
  logic       wrapped;
  logic [3:0] trig_addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  logic req = 1'b0;
  logic req_d = 1'b0;

  icetap_capture_ctrl #(.NR_SIGNALS(8), .DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .signals_in (signals_in),
    .start      (start),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .post_count (post_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .armed      (armed),
    .triggered  (triggered),
    .done       (done),
    .wrapped    (wrapped),
    .trig_addr  (trig_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) req_d <= req;

  // Kind 0: rd_data, 1: trig_addr, 2: {wrapped, done, triggered, armed}.
  always @(negedge clk) begin
    if (req_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: output presented with no expectation");
      end else begin
        exp_t e;
        logic [7:0] act;
        e = exp_q.pop_front();
        case (e.kind)
          0:       act = rd_data;
          1:       act = {4'h0, trig_addr};
          default: act = {4'h0, wrapped, done, triggered, armed};
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic probe(input int kind, input logic [3:0] addr, input logic [7:0] exp,
                       input string name);
    exp_t e;
    @(negedge clk);
    rd_addr = addr;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic check_now(input logic [7:0] act, input logic [7:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Ramp signals_in from base, pulsing start on the first cycle; returns the
  // loop index at which done was first seen, or -1 if the budget ran out.
  task automatic run(input logic [7:0] base, input int abort_at, input int budget,
                     output int done_at);
    done_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i > 0 && done) begin
        done_at = i;
        break;
      end
      signals_in = base + 8'(i);
      start      = (i == 0);
      abort      = (i == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_latency(input int act, input int exp, input string name);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: done seen at cycle %0d expected %0d", name, act, exp);
    end
  endtask

  int d;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_now({4'h0, wrapped, done, triggered, armed}, 8'h00, "reset_status");
    check_now({4'h0, trig_addr}, 8'h00, "reset_trig_addr");
    check_now(rd_data, 8'h00, "reset_rd_data");

    // Ramp, trigger on 5, three post samples.
    trig_mask = 8'hFF; trig_value = 8'h05; post_count = 4'd3;
    run(8'h00, -1, 40, d);
    check_latency(d, 10, "t1_done_latency");
    probe(2, 4'd0, 8'b0110, "t1_status");
    probe(1, 4'd0, 8'h05, "t1_trig_addr");
    for (int a = 5; a <= 8; a++) probe(0, 4'(a), 8'(a), "t1_mem");

    // Trigger on 20: buffer wraps once.
    trig_value = 8'h14;
    run(8'h00, -1, 40, d);
    check_latency(d, 25, "t2_done_latency");
    probe(2, 4'd0, 8'b1110, "t2_status");
    probe(1, 4'd0, 8'h04, "t2_trig_addr");
    probe(0, 4'd4, 8'h14, "t2_mem_trig");
    probe(0, 4'd8, 8'h08, "t2_mem_oldest");
    probe(0, 4'd7, 8'h17, "t2_mem_newest");

    // All-zero mask triggers on the first compared sample.
    trig_mask = 8'h00; post_count = 4'd0;
    run(8'h30, -1, 10, d);
    check_latency(d, 2, "t3_done_latency");
    probe(2, 4'd0, 8'b0110, "t3_status");
    probe(1, 4'd0, 8'h00, "t3_trig_addr");
    probe(0, 4'd0, 8'h30, "t3_mem0");

    // Maximum post count: writes stop just short of the trigger sample.
    trig_mask = 8'hFF; trig_value = 8'h42; post_count = 4'hF;
    run(8'h40, -1, 40, d);
    check_latency(d, 19, "t4_done_latency");
    probe(2, 4'd0, 8'b1110, "t4_status");
    probe(1, 4'd0, 8'h02, "t4_trig_addr");
    probe(0, 4'd2, 8'h42, "t4_mem_trig");
    probe(0, 4'd1, 8'h51, "t4_mem_last");
    probe(0, 4'd3, 8'h43, "t4_mem_first_post");

    // Abort in POST, then a fresh capture from address 0.
    trig_value = 8'h63; post_count = 4'd5;
    run(8'h60, 6, 10, d);
    check_latency(d, -1, "t5_abort_no_done");
    probe(2, 4'd0, 8'b0000, "t5_status_idle");
    probe(0, 4'd4, 8'h64, "t5_mem_before_abort");
    probe(0, 4'd5, 8'h45, "t5_mem_not_written");
    trig_value = 8'h82; post_count = 4'd1;
    run(8'h80, -1, 20, d);
    check_latency(d, 5, "t5b_done_latency");
    probe(1, 4'd0, 8'h02, "t5b_trig_addr");
    probe(0, 4'd0, 8'h80, "t5b_mem0");
    probe(0, 4'd3, 8'h83, "t5b_mem3");
    probe(0, 4'd4, 8'h64, "t5b_mem4_untouched");

    // Asynchronous reset mid-ARMED.
    trig_value = 8'hFF; post_count = 4'd2;
    run(8'hA0, -1, 5, d);
    check_now({7'h0, armed}, 8'h01, "t6_armed_before_reset");
    #2 reset = 1'b1;
    #1;
    check_now({4'h0, wrapped, done, triggered, armed}, 8'h00, "t6_async_status");
    check_now({4'h0, trig_addr}, 8'h00, "t6_async_trig_addr");
    check_now(rd_data, 8'h00, "t6_async_rd_data");
    @(negedge clk);
    reset = 1'b0;
    trig_value = 8'h11;
    run(8'h10, -1, 20, d);
    check_latency(d, 5, "t6b_done_latency");
    probe(2, 4'd0, 8'b0110, "t6b_status");
    probe(1, 4'd0, 8'h01, "t6b_trig_addr");
    for (int a = 1; a <= 3; a++) probe(0, 4'(a), 8'h10 + 8'(a), "t6b_mem");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icetap_capture_ctrl.md
# icetap_capture_ctrl

Sample-capture and trigger engine for IceTap, running in the source (design) clock domain. It registers `signals_in` and compares each sample against a masked trigger pattern. Samples are written into an internal circular buffer, and capture stops a programmable number of samples after the trigger. The JTAG scan side reads the frozen buffer and status through the read port once `done` is set, after synchronizing `done` into its own clock domain.

## Interface
Parameters:
- `NR_SIGNALS`, 1: width of each probed sample.
- `DEPTH_LOG2`, 8: log2 of buffer depth. DEPTH = 2^DEPTH_LOG2 samples.

Ports:
- `clk`  in  1  source clock. All logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `signals_in`  in  NR_SIGNALS  probed signals.
- `start`  in  1  single-cycle pulse that arms a new capture.
- `abort`  in  1  single-cycle pulse that returns the block to IDLE.
- `trig_mask`  in  NR_SIGNALS  bit=1 means the bit participates in the compare. Must be held stable while armed.
- `trig_value`  in  NR_SIGNALS  compare value.
- `post_count`  in  DEPTH_LOG2  number of samples stored after the trigger sample. Latched on `start`.
- `rd_addr`  in  DEPTH_LOG2  buffer read address.
- `rd_data`  out  NR_SIGNALS  buffer word. Registered, 1-cycle latency.
- `armed`  out  1  high in ARMED state.
- `triggered`  out  1  high in POST and DONE states.
- `done`  out  1  high in DONE state.
- `wrapped`  out  1  write pointer has wrapped at least once since `start`, so all DEPTH entries are valid.
- `trig_addr`  out  DEPTH_LOG2  buffer address of the trigger sample.

## Operation
- **Sample stage.** `sample <= signals_in` on every clock. All compares and writes use `sample`.
- **Trigger condition.** `hit = ((sample ^ trig_value) & trig_mask) == 0`.
  - An all-zero mask triggers on the first compared sample.
- **States:** IDLE, ARMED, POST, DONE.
- **IDLE**
  - No writes.
  - `start` → ARMED: `wr_addr <= 0`, `wrapped <= 0`, `post_cnt <= post_count` latched.
- **ARMED**
  - Each cycle: write `sample` at `wr_addr`, then `wr_addr <= wr_addr + 1`, wrapping mod DEPTH.
  - When `wr_addr` goes from DEPTH-1 to 0, set `wrapped`.
  - If `hit` in the same cycle: `trig_addr <= wr_addr` (the address just written).
    - If `post_cnt == 0` → DONE.
    - Otherwise → POST.
- **POST**
  - Each cycle: write and increment as in ARMED, and decrement `post_cnt`.
  - Entering the cycle with `post_cnt == 1` → DONE after that write.
  - The post-trigger samples are therefore stored at trig_addr+1 .. trig_addr+post_count, mod DEPTH.
- **DONE**
  - No writes. The buffer, `trig_addr` and `wrapped` are frozen until the next `start`.
- **post_count clamping.** If latched `post_count` exceeds DEPTH-1, it is clamped to DEPTH-1 at latch time, so the trigger sample is never overwritten.
- **Oldest valid sample.**
  - `wrapped=1`: the oldest valid sample is at final `wr_addr`.
  - `wrapped=0`: it is at address 0, and entries at `wr_addr`..DEPTH-1 are invalid.
- **Control precedence:** `abort` > `start` > state behaviour.
  - `abort` in any state → IDLE, with no write that cycle.
  - `start` in ARMED, POST or DONE restarts: same actions as from IDLE, and no write that cycle.
- **Read port.** `rd_data <= mem[rd_addr]` every clock, in any state.
  - Reads are only meaningful in DONE.
  - Read and write at the same address in the same cycle returns the old data.

## Timing
- **Reset** (asynchronous assert, synchronous deassert by the environment):
  - state = IDLE.
  - `armed`, `triggered`, `done`, `wrapped` = 0.
  - `trig_addr` = 0, `wr_addr` = 0, `post_cnt` = 0, `sample` = 0, `rd_data` = 0.
  - Memory contents are not reset.
- **Latency from `signals_in` to decision.** A value present at edge n is in `sample` after edge n, and is compared and written at edge n+1.
- **`start` to first write.** `start` seen at edge k: the first write is at edge k+1 (writing the sample taken at edge k), and `armed` is high after edge k.
- **Status outputs** are registered state decodes. They update on the edge that changes state.
- **Trigger to `done`.** Trigger at edge t sets `done` after edge t+post_count.
- **Reset mid-capture** discards the capture. Status returns to reset values immediately.

## Test plan
- NR_SIGNALS=8, DEPTH_LOG2=4, mask=0xFF, value=0x05, post_count=3; ramp `signals_in` 0,1,2,… from the cycle of `start` → trig_addr=5; done 3 cycles after trigger; mem[5..8]=5,6,7,8; wrapped=0.
- Same setup, value=0x14 (20) → wrapped=1; trig_addr=(20 mod 16)=4; final wr_addr=8 holds oldest sample 8; mem[4]=0x14.
- mask=0x00, post_count=0 → DONE on the first compared sample; trig_addr=0; triggered=done=1.
- post_count=0xF with DEPTH=16, trigger at addr 2 → clamped to 15; writes stop at addr 1; mem[2] still holds the trigger sample.
- Assert `abort` during POST → IDLE next edge; no further writes. Then `start` with a fresh pattern → new capture with wr_addr restarting at 0.
- Assert `reset` asynchronously mid-ARMED → all outputs 0 without a clock edge. After release, `start`+trigger produces a correct capture.
